// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver with receive FIFO.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_rx_state_t;

  localparam int unsigned UART_MIN_DIV = 32'd4;

  function automatic int unsigned uart_count_width(input int unsigned depth);
    return $clog2(depth) + 32'd1;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Generic first-word-fall-through FIFO; the head entry is visible on dout without a pop.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  // a pop frees a slot in the same cycle, so a full FIFO can still accept a push
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  // storage array, cleared so the head reads zero out of reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with runtime divider, FWFT receive FIFO and sticky error flags.
// Parity checking is built only when UART_RX_PARITY_EN is defined.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [31:0]                                 clk_div,
  input  logic                                        rx,
  input  logic                                        parity_en,
  input  logic                                        parity_odd,
  input  logic                                        read,
  input  logic                                        err_clr,
  input  logic                                        irq_en,
  output logic                                        irq,
  output logic [7:0]                                  rx_data,
  output logic                                        rx_valid,
  output logic [uart_count_width(FIFO_DEPTH)-1:0]     rx_count,
  output logic                                        frame_err,
  output logic                                        parity_err,
  output logic                                        overrun_err
);

  uart_rx_state_t       state, state_next;
  logic                 sync1, rx_s, rx_prev;
  logic [31:0]          tick, tick_next, div_eff, half;
  logic [3:0]           bit_cnt, bit_cnt_next;
  logic [DATA_BITS-1:0] shreg, shreg_next, head;
  logic                 par_bad, par_bad_next;
  logic                 bit_end, stop_done, good, push;
  logic                 fifo_full, fifo_empty;

  assign div_eff = (clk_div < UART_MIN_DIV) ? UART_MIN_DIV : clk_div;
  assign half    = div_eff >> 1;
  assign bit_end = (tick == div_eff - 32'd1);

  // two-flop synchronizer plus previous-sample register for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      sync1   <= rx;
      rx_s    <= sync1;
      rx_prev <= rx_s;
    end
  end

  // FSM and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      tick    <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      par_bad <= 1'b0;
    end else begin
      state   <= state_next;
      tick    <= tick_next;
      bit_cnt <= bit_cnt_next;
      shreg   <= shreg_next;
      par_bad <= par_bad_next;
    end
  end

  // next-state and sampling decisions
  always_comb begin
    state_next   = state;
    tick_next    = tick + 32'd1;
    bit_cnt_next = bit_cnt;
    shreg_next   = shreg;
    par_bad_next = par_bad;
    stop_done    = 1'b0;
    case (state)
      ST_IDLE: begin
        tick_next = '0;
        if (rx_prev && !rx_s) state_next = ST_START;
        else                  state_next = ST_IDLE;
      end
      ST_START: begin
        if (tick == half - 32'd1) begin
          tick_next    = '0;
          bit_cnt_next = '0;
          par_bad_next = 1'b0;
          if (!rx_s) state_next = ST_DATA;
          else       state_next = ST_IDLE;
        end else begin
          state_next = ST_START;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          tick_next    = '0;
          shreg_next   = {rx_s, shreg[DATA_BITS-1:1]};
          bit_cnt_next = bit_cnt + 4'd1;
          if (bit_cnt == 4'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
            state_next = parity_en ? ST_PARITY : ST_STOP;
`else
            state_next = ST_STOP;
`endif
          end else begin
            state_next = ST_DATA;
          end
        end else begin
          state_next = ST_DATA;
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (bit_end) begin
          tick_next    = '0;
          par_bad_next = (rx_s != (^shreg ^ parity_odd));
          state_next   = ST_STOP;
        end else begin
          state_next = ST_PARITY;
        end
      end
`endif
      ST_STOP: begin
        if (bit_end) begin
          tick_next  = '0;
          stop_done  = 1'b1;
          state_next = ST_IDLE;
        end else begin
          state_next = ST_STOP;
        end
      end
      default: begin
        tick_next  = '0;
        state_next = ST_IDLE;
      end
    endcase
  end

  assign good = stop_done & rx_s & ~par_bad;
  assign push = good & (~fifo_full | read);

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (shreg),
    .pop   (read),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (rx_count)
  );

  assign rx_data  = 8'(head);
  assign rx_valid = ~fifo_empty;

  // sticky frame and overrun flags; a new error wins over a coincident clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      frame_err   <= (stop_done & ~rx_s) | (frame_err & ~err_clr);
      overrun_err <= (good & fifo_full & ~read) | (overrun_err & ~err_clr);
    end
  end

`ifdef UART_RX_PARITY_EN
  // sticky parity flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) parity_err <= 1'b0;
    else     parity_err <= (stop_done & rx_s & par_bad) | (parity_err & ~err_clr);
  end
`else
  logic parity_unused;
  assign parity_unused = parity_en ^ parity_odd;
  assign parity_err    = 1'b0;
`endif

  assign irq = irq_en & (rx_valid | frame_err | parity_err | overrun_err);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized self-checking bench for uart_rx_fifo against a queue-based frame model.
`timescale 1ns/1ps
module tb_uart_rx_fifo;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst, rx, parity_en, parity_odd, read, err_clr, irq_en;
  logic [31:0]   clk_div;
  logic          irq, rx_valid, frame_err, parity_err, overrun_err;
  logic [7:0]    rx_data;
  logic [CW-1:0] rx_count;

  uart_rx_fifo #(.DATA_BITS(8), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .clk_div(clk_div), .rx(rx),
    .parity_en(parity_en), .parity_odd(parity_odd), .read(read),
    .err_clr(err_clr), .irq_en(irq_en), .irq(irq), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_count(rx_count), .frame_err(frame_err),
    .parity_err(parity_err), .overrun_err(overrun_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [7:0] mq[$];
  bit m_frame, m_parity, m_overrun;
  bit checking = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      check("rx_valid", 32'(rx_valid), 32'(mq.size() != 0));
      check("rx_count", 32'(rx_count), 32'(mq.size()));
      if (mq.size() != 0) check("rx_data", 32'(rx_data), 32'(mq[0]));
      check("frame_err", 32'(frame_err), 32'(m_frame));
      check("parity_err", 32'(parity_err), 32'(m_parity));
      check("overrun_err", 32'(overrun_err), 32'(m_overrun));
      check("irq", 32'(irq),
            32'(irq_en & ((mq.size() != 0) | m_frame | m_parity | m_overrun)));
    end
  end

  function automatic int eff_div();
    return (clk_div < 32'd4) ? 4 : int'(clk_div);
  endfunction

  function automatic bit par_active();
`ifdef UART_RX_PARITY_EN
    return parity_en;
`else
    return 1'b0;
`endif
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_frame = 1'b0; m_parity = 1'b0; m_overrun = 1'b0;
  endfunction

  function automatic void model_complete(input logic [7:0] d, input bit stop_ok, input bit par_ok);
    if (!stop_ok)                m_frame = 1'b1;
    else if (!par_ok)            m_parity = 1'b1;
    else if (mq.size() == DEPTH) m_overrun = 1'b1;
    else                         mq.push_back(d);
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    repeat (4) step();
    checking = 1'b1;
  endtask

  task automatic read_pulse();
    read = 1'b1; step(); read = 1'b0;
    if (mq.size() != 0) void'(mq.pop_front());
  endtask

  task automatic clr_pulse();
    err_clr = 1'b1; step(); err_clr = 1'b0;
    m_frame = 1'b0; m_parity = 1'b0; m_overrun = 1'b0;
  endtask

  // strobe: 0 none, 1 read, 2 err_clr, landing on the stop-sample edge (needs div >= 8)
  task automatic send_frame(input logic [7:0] d, input bit stop_bit, input bit par_flip, input int strobe);
    int  div  = eff_div();
    bit  pact = par_active();
    bit  bits[$];
    int  hs   = div / 2;
    checking = 1'b0;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (pact) bits.push_back((^d) ^ parity_odd ^ par_flip);
    for (int i = 0; i < bits.size(); i++) begin
      rx = bits[i];
      repeat (div) step();
    end
    rx = stop_bit;
    if (strobe != 0) begin
      repeat (2 + hs) step();
      if (strobe == 1) read = 1'b1; else err_clr = 1'b1;
      step();
      read = 1'b0; err_clr = 1'b0;
      if (strobe == 1 && mq.size() != 0) void'(mq.pop_front());
      if (strobe == 2) begin m_frame = 1'b0; m_parity = 1'b0; m_overrun = 1'b0; end
      repeat (div - 3 - hs) step();
    end else begin
      repeat (div) step();
    end
    model_complete(d, stop_bit, !pact || !par_flip);
    if (!stop_bit) begin
      rx = 1'b1;
      repeat (div) step();
    end
  endtask

  task automatic drain();
    while (mq.size() != 0) read_pulse();
    if (m_frame | m_parity | m_overrun) clr_pulse();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_valid"}, 32'(rx_valid), 32'd0);
    check({tag, "_count"}, 32'(rx_count), 32'd0);
    check({tag, "_data"}, 32'(rx_data), 32'd0);
    check({tag, "_flags"}, 32'({frame_err, parity_err, overrun_err}), 32'd0);
    check({tag, "_irq"}, 32'(irq), 32'd0);
  endtask

  initial begin
    rx = 1'b1; read = 1'b0; err_clr = 1'b0; irq_en = 1'b1;
    parity_en = 1'b0; parity_odd = 1'b0; clk_div = 32'd8; rst = 1'b1;
    model_reset();
    repeat (3) step();
    rst = 1'b0;
    step();
    check_reset_state("reset");
    checking = 1'b1;

    // single byte, then one read empties it
    send_frame(8'h41, 1'b1, 1'b0, 0);
    settle();
    check("a41_data", 32'(rx_data), 32'h41);
    check("a41_valid", 32'(rx_valid), 32'd1);
    check("a41_irq", 32'(irq), 32'd1);
    read_pulse();
    check("a41_read_valid", 32'(rx_valid), 32'd0);
    check("a41_read_irq", 32'(irq), 32'd0);

    // short low glitch must be rejected as a false start
    rx = 1'b0; repeat (3) step(); rx = 1'b1;
    repeat (16) step();
    check("glitch_count", 32'(rx_count), 32'd0);
    check("glitch_flags", 32'({frame_err, parity_err, overrun_err}), 32'd0);

    // stop bit low
    send_frame(8'h55, 1'b0, 1'b0, 0);
    settle();
    check("fe_flag", 32'(frame_err), 32'd1);
    check("fe_irq", 32'(irq), 32'd1);
    check("fe_count", 32'(rx_count), 32'd0);
    clr_pulse();
    check("fe_clr", 32'(frame_err), 32'd0);

`ifdef UART_RX_PARITY_EN
    parity_en = 1'b1; parity_odd = 1'b0;
    send_frame(8'h03, 1'b1, 1'b0, 0);
    send_frame(8'h03, 1'b1, 1'b1, 0);
    settle();
    check("par_count", 32'(rx_count), 32'd1);
    check("par_err", 32'(parity_err), 32'd1);
    check("par_data", 32'(rx_data), 32'h03);
    drain();
    parity_en = 1'b0;
`endif

    // five back-to-back frames into a four-entry FIFO
    for (int i = 0; i < 5; i++) send_frame(8'(8'h10 + i), 1'b1, 1'b0, 0);
    settle();
    check("ovr_count", 32'(rx_count), 32'd4);
    check("ovr_flag", 32'(overrun_err), 32'd1);
    for (int i = 0; i < 4; i++) begin
      check("ovr_read", 32'(rx_data), 32'h10 + 32'(i));
      read_pulse();
    end
    clr_pulse();

    // push into a full FIFO with a coincident read
    for (int i = 0; i < 4; i++) send_frame(8'(8'h20 + i), 1'b1, 1'b0, 0);
    send_frame(8'h24, 1'b1, 1'b0, 1);
    settle();
    check("fullrw_count", 32'(rx_count), 32'd4);
    check("fullrw_ovr", 32'(overrun_err), 32'd0);
    check("fullrw_head", 32'(rx_data), 32'h21);
    drain();

    // error event coinciding with err_clr keeps the flag set
    send_frame(8'h55, 1'b0, 1'b0, 2);
    settle();
    check("clr_vs_set", 32'(frame_err), 32'd1);
    clr_pulse();

    // reset in the middle of the data bits
    checking = 1'b0;
    rx = 1'b0; repeat (8) step();
    rx = 1'b1; repeat (8) step();
    rx = 1'b0; repeat (12) step();
    rst = 1'b1; rx = 1'b1;
    model_reset();
    repeat (3) step();
    rst = 1'b0;
    step();
    check_reset_state("midrst");
    checking = 1'b1;
    repeat (20) step();
    send_frame(8'h3C, 1'b1, 1'b0, 0);
    settle();
    check("midrst_data", 32'(rx_data), 32'h3C);
    check("midrst_count", 32'(rx_count), 32'd1);
    drain();

    // randomized traffic
    for (int it = 0; it < 40; it++) begin
      clk_div    = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(0, 3)) : 32'($urandom_range(6, 14));
      irq_en     = 1'($urandom_range(0, 1));
      parity_en  = 1'($urandom_range(0, 1));
      parity_odd = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 3))
        send_frame(8'($urandom), $urandom_range(0, 7) != 0, $urandom_range(0, 5) == 0, 0);
      settle();
      repeat ($urandom_range(2, 6)) step();
      repeat ($urandom_range(0, 3)) read_pulse();
      if ($urandom_range(0, 3) == 0) clr_pulse();
      repeat (2) step();
    end

    checking = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised UART receiver with a runtime bit-period divider, configurable data width, optional parity checking, a first-word-fall-through receive FIFO and sticky error flags. It is the next generation of the single-byte receiver and sits between the `rx` pad and the Wishbone register block. Software drains bytes with `read`. `irq` is a level interrupt on data-available or error.

## Interface
Parameters:
- DATA_BITS, 8, data bits per frame; legal range 5..8.
- FIFO_DEPTH, 16, receive FIFO entries; a power of two, at least 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- clk_div  in  32  bit period in clk cycles; values below 4 are treated as 4.
- rx  in  1  serial input, idle high, asynchronous to clk.
- parity_en  in  1  parity bit present after data (only with UART_RX_PARITY_EN).
- parity_odd  in  1  1 = odd parity, 0 = even parity.
- read  in  1  pop the FIFO head; ignored when the FIFO is empty.
- err_clr  in  1  clears all sticky error flags.
- irq_en  in  1  interrupt enable.
- irq  out  1  interrupt = irq_en & (rx_valid | any error flag).
- rx_data  out  8  FIFO head; zero-extended when DATA_BITS < 8; undefined-but-stable (hold last) when the FIFO is empty.
- rx_valid  out  1  FIFO not empty.
- rx_count  out  $clog2(FIFO_DEPTH)+1  occupancy.
- frame_err  out  1  sticky: stop bit sampled low.
- parity_err  out  1  sticky: parity mismatch.
- overrun_err  out  1  sticky: a frame completed while the FIFO was full.

## Operation
- `rx` passes through a 2-flop synchronizer; the FSM sees `rx_s`.
- Bit counter `tick` counts clk cycles. `half = clk_div >> 1`.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: a falling `rx_s` moves to START and clears `tick`.
  - START: at `tick == half-1`, sample `rx_s`. If low, go to DATA and clear `tick`. If high, this is a false start: return to IDLE with nothing pushed.
  - DATA: sample at each `tick == clk_div-1` and shift in LSB-first. After DATA_BITS samples, go to PARITY if enabled, else STOP.
  - PARITY: one sample. The computed parity is XOR of the data bits XOR parity_odd. A mismatch marks the frame bad-parity.
  - STOP: one sample. Then return to IDLE, which allows back-to-back frames with no extra idle time.
- Completion, on the cycle the stop bit is sampled:
  - stop low: set frame_err and push nothing.
  - parity mismatch: set parity_err and push nothing.
  - otherwise push, unless the FIFO is full with no simultaneous read; in that case drop the byte and set overrun_err.
- Full with a simultaneous read and push: both succeed, no overrun, rx_count unchanged.
- err_clr clears the flags. If err_clr coincides with a new error event, the set wins.
- clk_div is sampled continuously. Changing it mid-frame is illegal, and the resulting frame is undefined.

## Timing
- Reset values:
  - FSM in IDLE; synchronizer flops at 1.
  - FIFO empty; rx_valid = 0, rx_count = 0.
  - rx_data = 0.
  - All error flags = 0; irq = 0.
- Reset applied mid-frame aborts the frame; the partial byte is discarded.
- Pin-to-FSM latency is 2 clk cycles.
- Push is registered on the stop-sample edge. rx_valid, rx_count and rx_data reflect the push from that edge; rx_data is first-word-fall-through, so the head is visible without a read.
- read is a single-cycle pulse. The head advances at the next edge, and rx_count decrements at the same edge.
- irq is combinational from registered flags, so it follows them with zero added cycles.

## Configuration
- Macro: UART_RX_PARITY_EN.
- Defined: the PARITY state, parity_err and the parity_en/parity_odd inputs are functional.
- Undefined: the PARITY state is not generated and parity_en/parity_odd are ignored. The ports remain present so the port list does not change; parity_err is tied to 0.

## Structure
- Package uart_pkg holds:
  - the FSM state enum `uart_rx_state_t`;
  - the constant `UART_MIN_DIV = 4`;
  - the width helper for rx_count.
- Sub-module: uart_sync_fifo, a generic FWFT FIFO parameterised on WIDTH and DEPTH with push, pop, full, empty and count. The receiver FSM, synchronizer and error logic stay in uart_rx_fifo.

## Test plan
- clk_div = 8, DATA_BITS = 8, parity off. Send 0x41 (data bits LSB-first 1,0,0,0,0,0,1,0), stop = 1.
  -> rx_valid = 1, rx_data = 0x41, irq = 1.
  -> After one read pulse: rx_valid = 0, irq = 0.
- Low pulse of 3 clk on rx while idle, clk_div = 8 -> no push, FSM back in IDLE, all flags 0.
- Send 0x55 with the stop bit held low -> frame_err = 1, irq = 1, rx_count = 0.
  -> After an err_clr pulse: frame_err = 0.
- UART_RX_PARITY_EN defined, parity_en = 1, parity_odd = 0.
  -> 0x03 with parity bit 0: pushed.
  -> 0x03 with parity bit 1: parity_err = 1, not pushed.
- FIFO_DEPTH = 4. Send 5 back-to-back frames 0x10..0x14 with no reads.
  -> rx_count = 4, overrun_err = 1.
  -> Reads return 0x10, 0x11, 0x12, 0x13.
- Assert rst in the middle of the DATA state of 0xA5.
  -> All outputs at reset values; no byte appears.
  -> A following 0x3C is received correctly.
